// File: rtl/weight_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank_pkg
// Description : Shared types and default sizes for the double-buffered weight
//               bank: the burst-loader state encoding and the default weight
//               width / unit count used by weight_bank_dbuf.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_bank_pkg;

    // Burst loader states. The width is explicit so that the state register
    // is exactly one flop.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_UNITS = 4;

endpackage : weight_bank_pkg
`default_nettype wire

// File: rtl/weight_burst_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_burst_loader
// Description : Streamed-load sequencer for the shadow weight bank. After a
//               start request it accepts NUM_UNITS words, one per
//               in_valid && in_ready handshake, and issues a write strobe
//               plus index for each. Stalls indefinitely while in_valid low.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               start        - begin a burst (honoured only while idle)
//               in_valid     - burst data valid
//               in_ready     - loader will accept a word this cycle
//               busy         - burst in progress
//               load_done    - 1-cycle pulse after the last word is accepted
//               ld_stb       - write strobe into the shadow bank
//               ld_idx       - shadow bank index for ld_stb
// Revision    : 1.0 - initial release
// ============================================================================
module weight_burst_loader
    import weight_bank_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int ADDR_W    = $clog2(NUM_UNITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              load_done,
    output logic              ld_stb,
    output logic [ADDR_W-1:0] ld_idx
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_UNITS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_load_done;
    logic              w_load_done_nxt;
    logic              w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_load_done <= w_load_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_load_done_nxt = 1'b0;
        w_accept        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_BURST;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BURST: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
                        // Last word: leave BURST so in_ready drops on the
                        // same cycle that load_done pulses.
                        w_state_nxt     = ST_IDLE;
                        w_cnt_nxt       = '0;
                        w_load_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign in_ready  = (r_state == ST_BURST);
    assign busy      = (r_state == ST_BURST);
    assign load_done = r_load_done;
    assign ld_stb    = w_accept;
    assign ld_idx    = r_cnt;

endmodule : weight_burst_loader
`default_nettype wire

// File: rtl/weight_bank_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank_dbuf
// Description : Double-buffered weight store for NUM_UNITS neuron units.
//               Weights are loaded into a shadow bank (single addressed
//               writes or a streamed burst) and copied into the active bank
//               in one cycle by commit. Units see the active bank only, so
//               reloading never disturbs weights in use.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               wr_en/wr_addr/wr_data - single write into the shadow bank
//               burst_start           - begin streamed load of the shadow bank
//               in_valid/in_data      - burst data, accepted with in_ready
//               in_ready              - burst word accepted this cycle
//               commit                - copy shadow -> active
//               busy                  - burst in progress
//               load_done             - pulse after the last burst word
//               err                   - pulse on an illegal / ignored request
//               rd_shadow/rd_addr     - readback select (0=active, 1=shadow)
//               rd_data               - registered readback data
//               weights               - active bank, unit i at [i*DATA_W +: DATA_W]
// Revision    : 1.0 - initial release
// ============================================================================
module weight_bank_dbuf
    import weight_bank_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int ADDR_W    = $clog2(NUM_UNITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        burst_start,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        commit,
    output logic                        busy,
    output logic                        load_done,
    output logic                        err,
    input  logic                        rd_shadow,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_UNITS*DATA_W-1:0] weights
);

    // Unit count at one bit wider than an address, so that address range
    // checks stay meaningful when NUM_UNITS is not a power of two.
    localparam logic [ADDR_W:0] c_NUM_UNITS = (ADDR_W + 1)'(NUM_UNITS);

    logic [DATA_W-1:0] r_shadow [NUM_UNITS];
    logic [DATA_W-1:0] r_active [NUM_UNITS];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;

    logic              w_start;
    logic              w_ld_stb;
    logic [ADDR_W-1:0] w_ld_idx;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_ok;
    logic              w_commit_ok;
    logic              w_err;

    // A burst request while one is already running is an error, not a restart.
    assign w_start = burst_start && !busy;

    weight_burst_loader #(
        .NUM_UNITS (NUM_UNITS),
        .ADDR_W    (ADDR_W)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .load_done (load_done),
        .ld_stb    (w_ld_stb),
        .ld_idx    (w_ld_idx)
    );

    assign w_wr_in_range = ({1'b0, wr_addr} < c_NUM_UNITS);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_NUM_UNITS);

    // Single writes and commits are only honoured while idle; during a burst
    // the loader owns the shadow bank.
    assign w_wr_ok     = wr_en && !busy && w_wr_in_range;
    assign w_commit_ok = commit && !busy;

    assign w_err = (wr_en && !busy && !w_wr_in_range) ||
                   (busy && (wr_en || commit || burst_start));

    // Shadow bank. Single writes and burst writes never coincide because the
    // single write is blocked while the loader is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_shadow[wr_addr] <= wr_data;
            end
            if (w_ld_stb) begin
                r_shadow[w_ld_idx] <= in_data;
            end
        end
    end

    // Active bank. The copy reads the pre-edge shadow, so a write issued in
    // the same cycle as commit lands in the shadow bank only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_commit_ok) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_err;
            if (!w_rd_in_range) begin
                r_rd_data <= '0;
            end else if (rd_shadow) begin
                r_rd_data <= r_shadow[rd_addr];
            end else begin
                r_rd_data <= r_active[rd_addr];
            end
        end
    end

    assign rd_data = r_rd_data;
    assign err     = r_err;

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_weights
        assign weights[gi*DATA_W +: DATA_W] = r_active[gi];
    end

endmodule : weight_bank_dbuf
`default_nettype wire

// File: tb/tb_weight_bank_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_bank_dbuf
// Description : Self-checking bench for weight_bank_dbuf. A 4-unit instance
//               exercises reset, single writes, commit, bursts and error
//               pulses; a 6-unit instance covers non-power-of-two addressing.
//               Readback expectations go through a queue and are compared
//               when the registered rd_data appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_bank_dbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, burst_start, in_valid, commit, rd_shadow;
    logic [1:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data, in_data, rd_data;
    logic        in_ready, busy, load_done, err;
    logic [31:0] weights;

    logic        wr_en6, burst_start6, in_valid6, commit6, rd_shadow6;
    logic [2:0]  wr_addr6, rd_addr6;
    logic [7:0]  wr_data6, in_data6, rd_data6;
    logic        in_ready6, busy6, load_done6, err6;
    logic [47:0] weights6;

    weight_bank_dbuf #(.DATA_W(8), .NUM_UNITS(4)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .burst_start(burst_start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .commit(commit), .busy(busy), .load_done(load_done),
        .err(err), .rd_shadow(rd_shadow), .rd_addr(rd_addr), .rd_data(rd_data),
        .weights(weights)
    );

    weight_bank_dbuf #(.DATA_W(8), .NUM_UNITS(6)) u_dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
        .burst_start(burst_start6), .in_valid(in_valid6), .in_data(in_data6),
        .in_ready(in_ready6), .commit(commit6), .busy(busy6), .load_done(load_done6),
        .err(err6), .rd_shadow(rd_shadow6), .rd_addr(rd_addr6), .rd_data(rd_data6),
        .weights(weights6)
    );

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_addr;
        logic [7:0]  wr_data;
        logic        commit;
        logic        rd_sh;
        logic [1:0]  rd_addr;
        logic [7:0]  exp_rd;
        logic [31:0] exp_w;
        logic        exp_err;
    } vec_t;

    vec_t       tbl [16];
    logic [7:0] rd_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge. A pending readback is compared here.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("rd_data", {56'd0, rd_data}, {56'd0, e});
        end
    endtask

    task automatic rd_issue(input logic sh, input logic [1:0] a, input logic [7:0] e);
        rd_shadow = sh;
        rd_addr   = a;
        rd_q.push_back(e);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                                input logic cm, input logic sh, input logic [1:0] ra,
                                input logic [7:0] erd, input logic [31:0] ew);
        vec_t v;
        v.wr_en = we;  v.wr_addr = wa; v.wr_data = wd; v.commit = cm;
        v.rd_sh = sh;  v.rd_addr = ra; v.exp_rd = erd; v.exp_w = ew;
        v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic clear_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; burst_start = 0; in_valid = 0;
        in_data = 0; commit = 0; rd_shadow = 0; rd_addr = 0;
        wr_en6 = 0; wr_addr6 = 0; wr_data6 = 0; burst_start6 = 0; in_valid6 = 0;
        in_data6 = 0; commit6 = 0; rd_shadow6 = 0; rd_addr6 = 0;
    endtask

    initial begin
        // Reset sweep on both banks, single writes, then commit.
        for (int i = 0; i < 4; i++) tbl[i]     = mk(0, 0, 0, 0, 0, 2'(i), 8'h00, 32'h0);
        for (int i = 0; i < 4; i++) tbl[4 + i] = mk(0, 0, 0, 0, 1, 2'(i), 8'h00, 32'h0);
        tbl[8]  = mk(1, 0, 8'h11, 0, 1, 0, 8'h00, 32'h0);
        tbl[9]  = mk(1, 1, 8'h22, 0, 1, 0, 8'h11, 32'h0);
        tbl[10] = mk(1, 2, 8'h33, 0, 1, 1, 8'h22, 32'h0);
        tbl[11] = mk(1, 3, 8'h44, 0, 1, 2, 8'h33, 32'h0);
        tbl[12] = mk(0, 0, 8'h00, 0, 1, 3, 8'h44, 32'h0);
        tbl[13] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h44332211);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 0, 8'h11, 32'h44332211);
        tbl[15] = mk(0, 0, 8'h00, 0, 0, 3, 8'h44, 32'h44332211);

        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("reset_in_ready",  {63'd0, in_ready},  64'd0);
        chk("reset_busy",      {63'd0, busy},      64'd0);
        chk("reset_load_done", {63'd0, load_done}, 64'd0);
        chk("reset_err",       {63'd0, err},       64'd0);
        chk("reset_rd_data",   {56'd0, rd_data},   64'd0);
        chk("reset_weights",   {32'd0, weights},   64'd0);

        for (int i = 0; i < 16; i++) begin
            wr_en   = tbl[i].wr_en;
            wr_addr = tbl[i].wr_addr;
            wr_data = tbl[i].wr_data;
            commit  = tbl[i].commit;
            rd_issue(tbl[i].rd_sh, tbl[i].rd_addr, tbl[i].exp_rd);
            tick();
            chk("tbl_weights", {32'd0, weights}, {32'd0, tbl[i].exp_w});
            chk("tbl_err",     {63'd0, err},     {63'd0, tbl[i].exp_err});
        end
        clear_inputs();

        // Burst with in_valid gaps between every word.
        burst_start = 1;
        tick();
        burst_start = 0;
        chk("burst_busy",     {63'd0, busy},     64'd1);
        chk("burst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data  = 8'hA0 + 8'(i);
            tick();
            in_valid = 0;
            if (i < 3) begin
                chk("burst_mid_done", {63'd0, load_done}, 64'd0);
                tick();
                chk("burst_gap_busy", {63'd0, busy}, 64'd1);
            end
        end
        chk("burst_load_done", {63'd0, load_done}, 64'd1);
        chk("burst_end_ready", {63'd0, in_ready},  64'd0);
        chk("burst_end_busy",  {63'd0, busy},      64'd0);
        chk("burst_active",    {32'd0, weights},   64'h44332211);
        tick();
        chk("load_done_pulse", {63'd0, load_done}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd_issue(1, 2'(i), 8'hA0 + 8'(i));
            tick();
        end

        // Commit and single write in the same cycle.
        commit = 1; wr_en = 1; wr_addr = 1; wr_data = 8'h55;
        tick();
        commit = 0; wr_en = 0;
        chk("commit_wr_weights", {32'd0, weights}, 64'hA3A2A1A0);
        chk("commit_wr_err",     {63'd0, err},     64'd0);
        rd_issue(1, 1, 8'h55); tick();
        rd_issue(0, 1, 8'hA1); tick();

        // in_valid while idle is ignored without an error.
        in_valid = 1; in_data = 8'hFF;
        tick();
        in_valid = 0;
        chk("idle_valid_err",  {63'd0, err},  64'd0);
        chk("idle_valid_busy", {63'd0, busy}, 64'd0);
        rd_issue(1, 0, 8'hA0); tick();

        // Illegal requests during a burst.
        burst_start = 1; tick(); burst_start = 0;
        commit = 1; tick(); commit = 0;
        chk("err_commit_busy", {63'd0, err},     64'd1);
        chk("busy_commit_w",   {32'd0, weights}, 64'hA3A2A1A0);
        in_valid = 1; in_data = 8'hB0; tick(); in_valid = 0;
        chk("err_clears", {63'd0, err}, 64'd0);
        wr_en = 1; wr_addr = 0; wr_data = 8'hEE; tick(); wr_en = 0;
        chk("err_wr_busy", {63'd0, err}, 64'd1);
        burst_start = 1; in_valid = 1; in_data = 8'hB1; tick();
        burst_start = 0; in_valid = 0;
        chk("err_start_busy", {63'd0, err}, 64'd1);
        tick();
        chk("err_no_stretch", {63'd0, err}, 64'd0);
        chk("err_burst_busy", {63'd0, busy}, 64'd1);
        in_valid = 1; in_data = 8'hB2; tick();
        in_data = 8'hB3; tick(); in_valid = 0;
        chk("err_burst_done",   {63'd0, load_done}, 64'd1);
        chk("err_burst_active", {32'd0, weights},   64'hA3A2A1A0);
        for (int i = 0; i < 4; i++) begin
            rd_issue(1, 2'(i), 8'hB0 + 8'(i));
            tick();
        end

        // Reset in the middle of a burst.
        burst_start = 1; tick(); burst_start = 0;
        in_valid = 1; in_data = 8'hC0; tick();
        in_data = 8'hC1; tick(); in_valid = 0;
        rst = 1; tick(); rst = 0;
        chk("rst_mid_busy",    {63'd0, busy},      64'd0);
        chk("rst_mid_ready",   {63'd0, in_ready},  64'd0);
        chk("rst_mid_weights", {32'd0, weights},   64'd0);
        chk("rst_mid_done",    {63'd0, load_done}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd_issue(1, 2'(i), 8'h00);
            tick();
        end

        // Six-unit instance: address 5 is legal, address 7 is not.
        wr_en6 = 1; wr_addr6 = 5; wr_data6 = 8'h5A; tick();
        chk("u6_addr5_err", {63'd0, err6}, 64'd0);
        wr_addr6 = 7; wr_data6 = 8'h77; tick(); wr_en6 = 0;
        chk("u6_addr7_err", {63'd0, err6}, 64'd1);
        commit6 = 1; tick(); commit6 = 0;
        chk("u6_err_clear", {63'd0, err6},     64'd0);
        chk("u6_weights",   {16'd0, weights6}, 64'h5A00_0000_0000);
        rd_shadow6 = 1; rd_addr6 = 7; tick();
        chk("u6_rd_oob", {56'd0, rd_data6}, 64'd0);
        chk("u6_rd_oob_err", {63'd0, err6}, 64'd0);
        rd_addr6 = 5; tick();
        chk("u6_rd_addr5", {56'd0, rd_data6}, 64'h5A);

        if (rd_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_queue: got %0d pending expected 0", rd_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_weight_bank_dbuf
`default_nettype wire
